phase_sequencer: RTL

- Generates the one-hot instruction phase signals (F, R, X, M, W) that drive the program counter, register file, ALU and memory stages of the multi-cycle core.
- Stretches R and M while instruction or data memory is not ready.
- Counts retired instructions.
- Raises hlt on a decoded halt instruction or on a memory-wait timeout.
- hlt feeds back to the program counter's hlt input.

---
 rtl/phase_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer: one-hot F/R/X/M/W phases, memory-wait watchdog, halt and retire count.
// Define PHASE_SKIP_MEM_EN to let non-memory instructions go from X straight to W.
module phase_sequencer #(
    parameter int INSTRET_W = 32,
    parameter int WAIT_W    = 8,
    parameter int WAIT_MAX  = 255
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    input  logic                 need_mem,
    input  logic                 halt_dec,
    output logic                 phase_f,
    output logic                 phase_r,
    output logic                 phase_x,
    output logic                 phase_m,
    output logic                 phase_w,
    output logic                 hlt,
    output logic                 wait_err,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_F, S_R, S_X, S_M, S_W, S_HALT
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wdog_q, wdog_d;
    logic                 mem_q, mem_d;
    logic                 timeout;
    logic                 phase_f_q, phase_r_q, phase_x_q, phase_m_q, phase_w_q;
    logic                 hlt_q, wait_err_q;
    logic [INSTRET_W-1:0] instret_q;

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        mem_d   = mem_q;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_F;
            S_F: begin
                state_d = S_R;
                wdog_d  = '0;
            end
            S_R: begin
                if (imem_ready) begin
                    state_d = S_X;
                end else if (wdog_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    timeout = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_X: begin
                wdog_d = '0;
                if (halt_dec) begin
                    state_d = S_HALT;
                end else begin
`ifdef PHASE_SKIP_MEM_EN
                    state_d = need_mem ? S_M : S_W;
                    mem_d   = 1'b1;
`else
                    // Non-memory instructions pass through a single unwatched M cycle.
                    state_d = S_M;
                    mem_d   = need_mem;
`endif
                end
            end
            S_M: begin
                if (!mem_q || dmem_ready) begin
                    state_d = S_W;
                end else if (wdog_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    timeout = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_W:    state_d = S_F;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            wdog_q     <= '0;
            mem_q      <= 1'b0;
            phase_f_q  <= 1'b0;
            phase_r_q  <= 1'b0;
            phase_x_q  <= 1'b0;
            phase_m_q  <= 1'b0;
            phase_w_q  <= 1'b0;
            hlt_q      <= 1'b0;
            wait_err_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            mem_q      <= mem_d;
            phase_f_q  <= (state_d == S_F);
            phase_r_q  <= (state_d == S_R);
            phase_x_q  <= (state_d == S_X);
            phase_m_q  <= (state_d == S_M);
            phase_w_q  <= (state_d == S_W);
            hlt_q      <= (state_d == S_HALT);
            if (timeout) begin
                wait_err_q <= 1'b1;
            end
            if (state_q == S_W) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign phase_f  = phase_f_q;
    assign phase_r  = phase_r_q;
    assign phase_x  = phase_x_q;
    assign phase_m  = phase_m_q;
    assign phase_w  = phase_w_q;
    assign hlt      = hlt_q;
    assign wait_err = wait_err_q;
    assign instret  = instret_q;

endmodule
